// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared state encoding and default widths for the counter scheduler
package counter_sched_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/counter_sched_rr_arb2.sv
// rtl/counter_sched_rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end
endmodule

// File: rtl/counter_sched_ctrl.sv
// rtl/counter_sched_ctrl.sv - arbitrates two requesters onto an external counter and returns the counted value
module counter_sched_ctrl
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  input  logic [2*WIDTH-1:0]   req_start,
  input  logic [2*LEN_W-1:0]   req_len,
  output logic [1:0]           req_ready,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic                 done_id,
  output logic [WIDTH-1:0]     done_value,
  output logic                 cnt_load,
  output logic [WIDTH-1:0]     cnt_data,
  output logic                 cnt_oe,
  input  logic [WIDTH-1:0]     cnt_value
);
  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [WIDTH-1:0]   start_q, start_d;
  logic               id_q, id_d;
  logic [WIDTH-1:0]   done_value_q, done_value_d;
  logic               post_rst_q, post_rst_d;

  logic [1:0] arb_req;
  logic [1:0] grant;
  logic       accept;
  logic       gid;

  // Grants are blocked during reset and for the first cycle after it.
  assign arb_req = req_valid & {2{(state_q == ST_IDLE) && !reset && !post_rst_q}};
  assign accept  = |grant;
  assign gid     = grant[1];

  rr_arb2 u_arb (
    .req   (arb_req),
    .last  (last_q),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      remaining_q  <= '0;
      len_q        <= '0;
      start_q      <= '0;
      id_q         <= 1'b0;
      done_value_q <= '0;
      post_rst_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      remaining_q  <= remaining_d;
      len_q        <= len_d;
      start_q      <= start_d;
      id_q         <= id_d;
      done_value_q <= done_value_d;
      post_rst_q   <= post_rst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    remaining_d  = remaining_q;
    len_d        = len_q;
    start_d      = start_q;
    id_d         = id_q;
    done_value_d = done_value_q;
    post_rst_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          start_d = gid ? req_start[2*WIDTH-1:WIDTH] : req_start[WIDTH-1:0];
          len_d   = gid ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
          id_d    = gid;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        remaining_d = len_q;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (remaining_q == '0) begin
          done_value_d = cnt_value;
          state_d      = ST_DONE;
        end else begin
          remaining_d = remaining_q - LEN_W'(1);
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = grant;
    done_valid = (state_q == ST_DONE) && !reset;
    cnt_load   = (state_q == ST_LOAD) && !reset;
    cnt_data   = cnt_load ? start_q : '0;
    cnt_oe     = (state_q != ST_IDLE) && !reset;
    done_id    = id_q;
    done_value = done_value_q;
  end
endmodule

// File: tb/tb_counter_sched_ctrl.sv
// tb/tb_counter_sched_ctrl.sv - self-checking bench for counter_sched_ctrl with a behavioural counter and scheduler model
module tb_counter_sched_ctrl;
  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0][7:0] st;
  logic [1:0][3:0] ln;
  logic [15:0]     req_start;
  logic [7:0]      req_len;
  logic [1:0]      req_ready;
  logic            done_valid;
  logic            done_ready;
  logic            done_id;
  logic [7:0]      done_value;
  logic            cnt_load;
  logic [7:0]      cnt_data;
  logic            cnt_oe;
  logic [7:0]      cnt_value = 8'h00;

  int n_assert = 0;
  int n_fail   = 0;
  int last_m   = 1;

  assign req_start = st;
  assign req_len   = ln;

  always #5 clk = ~clk;

  // Free-running external counter: loads on cnt_load, otherwise counts up.
  always @(posedge clk) begin
    if (cnt_load) cnt_value <= cnt_data;
    else          cnt_value <= cnt_value + 8'd1;
  end

  counter_sched_ctrl #(.WIDTH(8), .LEN_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_start  (req_start),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .done_id    (done_id),
    .done_value (done_value),
    .cnt_load   (cnt_load),
    .cnt_data   (cnt_data),
    .cnt_oe     (cnt_oe),
    .cnt_value  (cnt_value)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_dvalid"}, 32'(done_valid), 0);
    chk({tag, "_load"}, 32'(cnt_load), 0);
    chk({tag, "_data"}, 32'(cnt_data), 0);
    chk({tag, "_oe"}, 32'(cnt_oe), 0);
  endtask

  function automatic int winner(input logic [1:0] v);
    if (v == 2'b11) return (last_m == 1) ? 0 : 1;
    return v[1] ? 1 : 0;
  endfunction

  // Runs one job from the IDLE state through the done handshake.
  task automatic do_job(input logic [1:0] v, input int hold);
    int         wid;
    logic [7:0] exp_val;
    int         exp_lat;
    int         cyc;
    req_valid = v;
    #1;
    wid     = winner(v);
    exp_val = st[wid] + 8'(ln[wid]);
    exp_lat = 3 + int'(ln[wid]);
    chk("grant", 32'(req_ready), 32'(1 << wid));
    step();
    cyc = 1;
    chk("load_pulse", 32'(cnt_load), 1);
    chk("load_data", 32'(cnt_data), 32'(st[wid]));
    chk("load_oe", 32'(cnt_oe), 1);
    chk("load_ready", 32'(req_ready), 0);
    step();
    cyc = 2;
    while (!done_valid && cyc < 40) begin
      if (cnt_load || cnt_data != 8'h00 || req_ready != 2'b00 || !cnt_oe)
        chk("run_outputs", {cnt_load, cnt_oe, req_ready, cnt_data}, {1'b0, 1'b1, 2'b00, 8'h00});
      step();
      cyc++;
    end
    chk("done_seen", 32'(done_valid), 1);
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("done_id", 32'(done_id), 32'(wid));
    chk("done_value", 32'(done_value), 32'(exp_val));
    done_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(done_valid), 1);
      chk("hold_value", 32'(done_value), 32'(exp_val));
      chk("hold_id", 32'(done_id), 32'(wid));
      chk("hold_ready", 32'(req_ready), 0);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    last_m = wid;
    chk("idle_after_done", 32'({done_valid, cnt_oe}), 0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b11;
    done_ready = 1'b0;
    st[0] = 8'h10; ln[0] = 4'd5;
    st[1] = 8'hFA; ln[1] = 4'd10;
    step();
    chk_quiet("in_reset");
    step();
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_done_value", 32'(done_value), 0);
    reset = 1'b0;
    #1;
    chk_quiet("post_reset");
    step();

    do_job(2'b11, 0);
    do_job(2'b11, 6);
    st[0] = 8'h7F; ln[0] = 4'd0;
    do_job(2'b11, 0);

    req_valid = 2'b10;
    st[1] = 8'h33; ln[1] = 4'd8;
    #1;
    chk("abort_grant", 32'(req_ready), 2);
    step();
    req_valid = 2'b00;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    chk_quiet("abort_in_reset");
    step();
    reset = 1'b0;
    #1;
    chk_quiet("abort_after");
    chk("abort_value", 32'(done_value), 0);
    last_m = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (done_valid || cnt_oe) chk("abort_no_done", 32'({done_valid, cnt_oe}), 0);
    end
    chk("abort_quiet_end", 32'({done_valid, cnt_oe}), 0);
    st[0] = 8'h20; ln[0] = 4'd3;
    do_job(2'b01, 1);

    for (int j = 0; j < 25; j++) begin
      st[0] = 8'($urandom);
      st[1] = 8'($urandom);
      ln[0] = 4'($urandom);
      ln[1] = 4'($urandom);
      do_job(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
    end

    req_valid = 2'b00;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_sched_ctrl.md
COUNTER_SCHED_CTRL -- requirements
Module: counter_sched_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter and data width.
REQ-002 SHALL have parameter LEN_W, default 4: run-length field width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 2: per-requester request valid, bit i = requester i.
REQ-006 SHALL have port req_start, input, 2*WIDTH: per-requester start value, bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_len, input, 2*LEN_W: per-requester run length in cycles, bits [i*LEN_W +: LEN_W].
REQ-008 SHALL have port req_ready, output, 2: per-requester accept.
REQ-009 SHALL have port done_valid, output, 1: result available.
REQ-010 SHALL have port done_ready, input, 1: result consumer accept.
REQ-011 SHALL have port done_id, output, 1: requester index the result belongs to.
REQ-012 SHALL have port done_value, output, WIDTH: captured counter value.
REQ-013 SHALL have port cnt_load, output, 1: drives the counter's load input.
REQ-014 SHALL have port cnt_data, output, WIDTH: drives the counter's data_in input.
REQ-015 SHALL have port cnt_oe, output, 1: drives the counter's output enable.
REQ-016 SHALL have port cnt_value, input, WIDTH: the counter's count output.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN, DONE; one state per cycle except where stated.
REQ-018 In IDLE with any req_valid high, SHALL grant exactly one requester: req_ready[g]=1 combinationally for the winner only; the handshake completes that cycle; it latches start, len and id; next state LOAD.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset, requester 0 wins the first tie.
REQ-020 req_ready SHALL be 0 in all states other than IDLE; a valid dropped before grant SHALL have no effect.
REQ-021 In LOAD, SHALL assert cnt_load=1, cnt_data=latched start; next state RUN with remaining=len.
REQ-022 In RUN, cnt_load=0; each cycle: if remaining==0, capture cnt_value into done_value and go to DONE; else remaining decrements by 1.
REQ-023 Captured value SHALL equal (start+len) mod 2^WIDTH: wrap-around is inherited from the counter; len=0 captures start.
REQ-024 In DONE, done_valid=1 and done_id/done_value SHALL be held stable until done_ready=1; on done_ready, update the last-grant pointer and go to IDLE.
REQ-025 Latency: request accepted in cycle T -> done_valid first high in cycle T+3+len.
REQ-026 cnt_oe SHALL be 1 in LOAD, RUN and DONE, and 0 in IDLE.
REQ-027 cnt_data SHALL be 0 whenever cnt_load=0.
REQ-028 Requests arriving outside IDLE SHALL wait; they SHALL NOT be dropped or queued internally.

Reset
REQ-029 reset high at a clock edge SHALL force IDLE, last-grant=1, remaining=0, done_value=0, done_id=0, from any state including mid-RUN.
REQ-030 While in reset and the cycle after: req_ready=0, done_valid=0, cnt_load=0, cnt_data=0, cnt_oe=0.
REQ-031 An in-flight job aborted by reset SHALL produce no done_valid.

Structure
REQ-032 Package counter_sched_pkg SHALL hold the state encoding and the WIDTH and LEN_W default constants.
REQ-033 Arbitration SHALL be a sub-module rr_arb2 (2-way round-robin: inputs req[1:0] and last; output one-hot grant).
REQ-034 The counter itself SHALL be external and SHALL NOT be instantiated in this block.

Verification
REQ-035 Single job: req0 start=0x10 len=5 -> cnt_load pulse with cnt_data=0x10; done_valid at T+8; done_id=0; done_value=0x15.
REQ-036 Wrap: req1 start=0xFA len=10 -> done_value=0x04, done_id=1.
REQ-037 Tie: both valid from reset -> order req0, req1, req0; each grant is one-hot and one cycle long.
REQ-038 Backpressure: done_ready low for 6 cycles -> done_valid/value held; req_ready stays 0 until done_ready is accepted.
REQ-039 Reset mid-RUN: reset at RUN cycle 2 -> IDLE next cycle; all outputs 0; no done_valid; next job correct.
REQ-040 len=0: start=0x7F -> done_value=0x7F at T+3.
